// File: rtl/if_fetch_buf_if.sv
// Instruction-bus and decode-handshake bundle for if_fetch_buf.
// master: the fetch buffer; slave: the memory/decode side.
interface if_fetch_buf_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;

  modport master (
    output mem_req, mem_addr, id_valid, id_pc, id_inst,
    input  mem_gnt, mem_rvalid, mem_rdata, id_ready
  );

  modport slave (
    input  mem_req, mem_addr, id_valid, id_pc, id_inst,
    output mem_gnt, mem_rvalid, mem_rdata, id_ready
  );
endinterface

// File: rtl/if_fetch_buf.sv
// Fetch buffer: one outstanding req/gnt/rvalid fetch, (pc, inst) FIFO to decode.
// Optional same-cycle bypass of returned data to decode: IF_FETCH_BUF_BYPASS_EN.
module if_fetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] inst_addr,
  input  logic        inst_ena,
  input  logic        flush,
  output logic [1:0]  fetch_stall,
  if_fetch_buf_if.master bus
);

  localparam int unsigned CNT_W = PTR_W + 1;
  // Stall encoding shared with the PC stage
  localparam logic [1:0] STALL_NEXT = 2'b01;
  localparam logic [1:0] STALL_KEEP = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [63:0]       addr_q, addr_d;
  logic [63:0]       pc_q   [DEPTH];
  logic [63:0]       pc_d   [DEPTH];
  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       inst_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rsp_c, push_c, pop_c, stall_next_c;

  // Request FSM; flush overrides every state
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    rsp_c        = 1'b0;
    stall_next_c = flush;
    case (state_q)
      IDLE: begin
        if (!flush && inst_ena && (count_q < CNT_W'(DEPTH))) begin
          addr_d  = inst_addr;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          req_d        = 1'b0;
          stall_next_c = 1'b1;
          state_d      = flush ? DROP : WAIT;
        end else if (flush) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rsp_c   = !flush;
          state_d = IDLE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (bus.mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef IF_FETCH_BUF_BYPASS_EN
  logic byp_c;
  assign byp_c        = rsp_c && (count_q == '0);
  assign push_c       = rsp_c && !(byp_c && bus.id_ready);
  assign bus.id_valid = byp_c || (count_q != '0);
  assign bus.id_pc    = byp_c ? addr_q : pc_q[rd_ptr_q];
  assign bus.id_inst  = byp_c ? bus.mem_rdata : inst_q[rd_ptr_q];
`else
  assign push_c       = rsp_c;
  assign bus.id_valid = (count_q != '0);
  assign bus.id_pc    = pc_q[rd_ptr_q];
  assign bus.id_inst  = inst_q[rd_ptr_q];
`endif

  assign pop_c = (count_q != '0) && bus.id_ready;

  // FIFO bookkeeping; pushes never coincide with flush
  always_comb begin
    pc_d     = pc_q;
    inst_d   = inst_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      pc_d[wr_ptr_q]   = addr_q;
      inst_d[wr_ptr_q] = bus.mem_rdata;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
    end
  end

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign fetch_stall  = (!rst && stall_next_c) ? STALL_NEXT : STALL_KEEP;

endmodule

// File: tb/tb_if_fetch_buf.sv
// Bench for if_fetch_buf: directed scenarios then constrained-random traffic,
// every cycle compared against a transaction-level model.
module tb_if_fetch_buf;

  localparam int unsigned DEPTH = 2;
  localparam logic [1:0] S_NEXT = 2'b01;
  localparam logic [1:0] S_KEEP = 2'b10;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] inst_addr;
  logic        inst_ena;
  logic        flush;
  logic [1:0]  fetch_stall;

  if_fetch_buf_if bus ();

  if_fetch_buf #(.DEPTH(DEPTH), .PTR_W(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_addr  (inst_addr),
    .inst_ena   (inst_ena),
    .flush      (flush),
    .fetch_stall(fetch_stall),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  // Model: a pending (ungranted) request, an awaited response that may be
  // marked for discard, and the ordered list of buffered fetches.
  logic        m_pend = 1'b0;
  logic        m_wait = 1'b0;
  logic        m_drop = 1'b0;
  logic [63:0] m_addr = '0;
  ent_t        q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic i_rst, input logic i_ena, input logic [63:0] i_addr,
                      input logic i_flush, input logic i_gnt, input logic i_rvalid,
                      input logic [31:0] i_rdata, input logic i_ready);
    logic        exp_byp;
    logic        exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_inst;
    logic        do_push;
    @(posedge clk);
    #1;
    rst            = i_rst;
    inst_ena       = i_ena;
    inst_addr      = i_addr;
    flush          = i_flush;
    bus.mem_gnt    = i_gnt;
    bus.mem_rvalid = i_rvalid;
    bus.mem_rdata  = i_rdata;
    bus.id_ready   = i_ready;
    #3;
    exp_byp = 1'b0;
`ifdef IF_FETCH_BUF_BYPASS_EN
    exp_byp = !i_rst && m_wait && !m_drop && i_rvalid && !i_flush && (q.size() == 0);
`endif
    exp_valid = exp_byp || (q.size() > 0);
    exp_pc    = exp_byp ? m_addr : ((q.size() > 0) ? q[0].pc : 64'd0);
    exp_inst  = exp_byp ? i_rdata : ((q.size() > 0) ? q[0].inst : 32'd0);

    chk("fetch_stall", 64'(fetch_stall),
        64'((!i_rst && (i_flush || (m_pend && i_gnt))) ? S_NEXT : S_KEEP));
    if (!i_rst) begin
      chk("mem_req", 64'(bus.mem_req), 64'(m_pend));
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("id_valid", 64'(bus.id_valid), 64'(exp_valid));
      if (exp_valid) begin
        chk("id_pc", bus.id_pc, exp_pc);
        chk("id_inst", 64'(bus.id_inst), 64'(exp_inst));
      end
    end

    if (i_rst) begin
      m_pend = 1'b0;
      m_wait = 1'b0;
      m_drop = 1'b0;
      m_addr = '0;
      q.delete();
    end else begin
      do_push = 1'b0;
      if (m_pend) begin
        if (i_gnt) begin
          m_pend = 1'b0;
          m_wait = 1'b1;
          m_drop = i_flush;
        end else if (i_flush) begin
          m_pend = 1'b0;
        end
      end else if (m_wait) begin
        if (i_rvalid) begin
          do_push = !m_drop && !i_flush && !(exp_byp && i_ready);
          m_wait  = 1'b0;
          m_drop  = 1'b0;
        end else if (i_flush) begin
          m_drop = 1'b1;
        end
      end else if (i_ena && !i_flush && (q.size() < DEPTH)) begin
        m_pend = 1'b1;
        m_addr = i_addr;
      end
      if (i_flush) begin
        q.delete();
      end else begin
        if ((q.size() > 0) && i_ready) void'(q.pop_front());
        if (do_push) q.push_back('{pc: m_addr, inst: i_rdata});
      end
    end
  endtask

  task automatic idle_step(input logic i_ready);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, i_ready);
  endtask

  initial begin
    logic        r_ena, r_flush, r_gnt, r_rvalid, r_ready, r_rst;
    logic [63:0] r_addr;

    // Reset and single fetch with latency
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle_step(1'b0);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
    chk("rst_id_pc", bus.id_pc, 64'd0);
    chk("rst_id_inst", 64'(bus.id_inst), 64'd0);
    step(1'b0, 1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    idle_step(1'b0);
    chk("a_req", 64'(bus.mem_req), 64'd1);
    chk("a_addr", bus.mem_addr, 64'h8000_0000);
    idle_step(1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("a_stall_gnt", 64'(fetch_stall), 64'(S_NEXT));
    idle_step(1'b0);
    chk("a_stall_wait", 64'(fetch_stall), 64'(S_KEEP));
    idle_step(1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
`ifdef IF_FETCH_BUF_BYPASS_EN
    chk("a_valid_rv", 64'(bus.id_valid), 64'd1);
`else
    chk("a_valid_rv", 64'(bus.id_valid), 64'd0);
`endif
    idle_step(1'b0);
    chk("a_valid", 64'(bus.id_valid), 64'd1);
    chk("a_pc", bus.id_pc, 64'h8000_0000);
    chk("a_inst", 64'(bus.id_inst), 64'h13);

    // Fill the FIFO, issue blocked until a pop, in-order delivery
    step(1'b0, 1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h0040_0093, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("b_full_noreq", 64'(bus.mem_req), 64'd0);
    end
    step(1'b0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("b_pop0", bus.id_pc, 64'h8000_0000);
    step(1'b0, 1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("b_head1", bus.id_pc, 64'h8000_0004);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("b_req2", bus.mem_addr, 64'h8000_0008);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h0080_0093, 1'b0);
    idle_step(1'b1);
    chk("b_pop1", 64'(bus.id_inst), 64'h0040_0093);
    idle_step(1'b1);
    chk("b_pop2", bus.id_pc, 64'h8000_0008);
    idle_step(1'b0);
    chk("b_empty", 64'(bus.id_valid), 64'd0);

    // Flush while waiting for data, then redirected fetch
    step(1'b0, 1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 64'h8000_1000, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("c_stall_flush", 64'(fetch_stall), 64'(S_NEXT));
    step(1'b0, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("c_drop_valid", 64'(bus.id_valid), 64'd0);
    step(1'b0, 1'b1, 64'h8000_1000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("c_no_push", 64'(bus.id_valid), 64'd0);
    idle_step(1'b0);
    chk("c_redirect", bus.mem_addr, 64'h8000_1000);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    idle_step(1'b1);
    chk("c_pc", bus.id_pc, 64'h8000_1000);

    // Flush coincident with grant: response dropped
    step(1'b0, 1'b1, 64'h8000_2000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("d_stall", 64'(fetch_stall), 64'(S_NEXT));
    step(1'b0, 1'b1, 64'h8000_2100, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("d_noreq", 64'(bus.mem_req), 64'd0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h1111_1111, 1'b0);
    idle_step(1'b0);
    chk("d_nopush", 64'(bus.id_valid), 64'd0);

    // Reset while waiting, then a stray response
    step(1'b0, 1'b1, 64'h8000_3000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h2222_2222, 1'b0);
    chk("e_addr", bus.mem_addr, 64'd0);
    chk("e_inst", 64'(bus.id_inst), 64'd0);
    idle_step(1'b0);
    chk("e_valid", 64'(bus.id_valid), 64'd0);

    // Empty FIFO, decode ready when the data returns
    step(1'b0, 1'b1, 64'h8000_4000, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 32'h0010_0093, 1'b1);
`ifdef IF_FETCH_BUF_BYPASS_EN
    chk("f_byp_valid", 64'(bus.id_valid), 64'd1);
    chk("f_byp_inst", 64'(bus.id_inst), 64'h0010_0093);
    idle_step(1'b1);
    chk("f_byp_count0", 64'(bus.id_valid), 64'd0);
`else
    chk("f_valid", 64'(bus.id_valid), 64'd0);
    idle_step(1'b1);
    chk("f_inst", 64'(bus.id_inst), 64'h0010_0093);
`endif

    // Constrained-random traffic obeying the bus protocol
    for (int n = 0; n < 4000; n++) begin
      r_rst    = ($urandom % 300) == 0;
      r_ena    = ($urandom % 4) != 0;
      r_addr   = {$urandom, $urandom} & ~64'h3;
      r_flush  = ($urandom % 12) == 0;
      r_gnt    = m_pend && (($urandom % 3) == 0);
      r_rvalid = m_wait && (($urandom % 3) == 0);
      r_ready  = ($urandom % 2) == 0;
      step(r_rst, r_ena, r_addr, r_flush, r_gnt, r_rvalid, $urandom, r_ready);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
